bit_serial_adder: RTL and testbench

- Sequential LSB-first serial adder. Sits directly upstream of the 1-bit full-adder stage and drives it one bit per clock.
- Each cycle it presents a[i], b[i] and the registered carry to the full-adder cell.
- It captures the sum bit into a result shift register and feeds the carry-out back for the next bit.
- Handles one WIDTH-bit addition at a time under a start/busy/done handshake.

---
 rtl/bit_serial_adder.sv | 73 +++++++
 tb/tb_bit_serial_adder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder feeding a 1-bit full-adder cell under a start/busy/done handshake.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output ovf.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] sha, shb, res;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_c, last, load;
  always_comb begin
    fa_s = sha[0] ^ shb[0] ^ carry;
    fa_c = (sha[0] & shb[0]) | (carry & (sha[0] ^ shb[0]));
    last = cnt == CW'(WIDTH - 1);
    load = start && state != RUN;
    nxt  = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sha   <= '0;
      shb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (load) begin
      sha   <= a;
      shb   <= b;
      carry <= cin;
      cnt   <= '0;
      res   <= '0;
    end else if (state == RUN) begin
      res   <= {fa_s, res[WIDTH-1:1]};
      sha   <= sha >> 1;
      shb   <= shb >> 1;
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_s, res[WIDTH-1:1]};
        cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
        // carry still holds the carry into the MSB on the last bit
        ovf  <= carry ^ fa_c;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: table-driven vectors plus handshake/reset sequences, scoreboard checked on done.
module tb_bit_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
`endif
  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;
  vec_t vecs[8];
  logic [9:0] q[$];
  logic [9:0] mon_e;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, mon_e[7:0]});
        chk("cout", {31'd0, cout}, {31'd0, mon_e[8]});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e[9]});
`endif
      end
    end
  task automatic run_op(input vec_t v);
    int n, bc;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    q.push_back({v.ov, v.co, v.s});
    @(negedge clk);
    start = 1'b0; n = 1; bc = 0;
    while (!done && n < 40) begin
      bc += int'(busy);
      @(negedge clk);
      n++;
    end
    chk("latency", n, 9);
    chk("busy_cycles", bc, 8);
    repeat (2) @(negedge clk);
    chk("hold_sum", {24'd0, sum}, {24'd0, v.s});
    chk("hold_cout", {31'd0, cout}, {31'd0, v.co});
    chk("done_single", {31'd0, done}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    logic seen, bad;
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_sum", {24'd0, sum}, 0);
      chk("rst_cout", {31'd0, cout}, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_start", {31'd0, busy}, 0);
    for (int i = 0; i < 8; i++) run_op(vecs[i]);
    // start and operand changes during RUN must be ignored
    @(negedge clk);
    a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
    q.push_back({2'b00, 8'h7F});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("ignore_q_empty", q.size(), 0);
    chk("ignore_sum", {24'd0, sum}, 32'h7F);
    // back-to-back: start held through DONE reloads immediately
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    q.push_back({2'b00, 8'h33});
    @(negedge clk);
    a = 8'h40; b = 8'h05;
    q.push_back({2'b00, 8'h45});
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", n, 9);
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("b2b_reload_busy", {31'd0, busy}, 1);
    bad = 1'b0;
    while (!done && n < 60) begin
      if (sum !== 8'h33) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("b2b_sum_stable", {31'd0, bad}, 0);
    chk("b2b_second_done", n, 18);
    repeat (2) @(negedge clk);
    // reset at bit 4 aborts without a done
    @(negedge clk);
    a = 8'hC8; b = 8'h64; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_sum", {24'd0, sum}, 0);
    chk("abort_cout", {31'd0, cout}, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 0);
    run_op(vecs[7]);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
